// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

    // Arbiter state, derived from the multdiv holding buffer's occupancy.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        HELD    = 2'b01,
        STARVED = 2'b10
    } arb_state_e;

    // Architectural zero register; writes to it are dropped.
    localparam int REG_ZERO = 0;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for a completed multdiv result awaiting the write port.
module wb_hold_buf
    import wb_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              drain_i,
    input  logic              kill_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [WIDTH-1:0]  data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]  data_q;

    // Load only happens while empty, so it never competes with drain/kill.
    // Contents are zeroed whenever the entry is released so the pend_* view is clean.
    always_ff @(posedge clk) begin
        if (clr || drain_i || kill_i) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            rd_q    <= rd_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the W stage and multdiv.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              wb_stall,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [WIDTH-1:0]  md_data,
    output logic              md_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [WIDTH-1:0]  rf_data,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_rd,
    output logic [WIDTH-1:0]  pend_data
);

    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_inc;
    logic              grant_buf, grant_wb;
    logic              buf_load, buf_drain, buf_kill;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [WIDTH-1:0]  rf_data_q, rf_data_d;

    wb_hold_buf #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk     (clk),
        .clr     (clr),
        .load_i  (buf_load),
        .rd_i    (md_rd),
        .data_i  (md_data),
        .drain_i (buf_drain),
        .kill_i  (buf_kill),
        .valid_o (pend_valid),
        .rd_o    (pend_rd),
        .data_o  (pend_data)
    );

    // Grant selection: a starved buffer beats the pipeline, otherwise the pipeline wins.
    always_comb begin
        grant_buf = 1'b0;
        grant_wb  = 1'b0;
        wb_stall  = 1'b0;
        md_ready  = (state_q == EMPTY) && !clr;
        if (state_q == STARVED) begin
            grant_buf = 1'b1;
            wb_stall  = wb_valid && !clr;
        end else if (wb_valid) begin
            grant_wb = 1'b1;
        end else if (state_q == HELD) begin
            grant_buf = 1'b1;
        end
        // Results for r0 are accepted but never occupy the buffer.
        buf_load  = md_valid && md_ready && (md_rd != RD_ZERO);
        buf_drain = grant_buf && (state_q != EMPTY);
        // A younger pipeline write to the same register makes the buffered value dead.
        buf_kill  = (state_q == HELD) && grant_wb && (wb_rd == pend_rd) && (wb_rd != RD_ZERO);
    end

    // Next-state and lost-slot counter update.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + CNT_W'(1);
        case (state_q)
            EMPTY: begin
                if (buf_load) begin
                    state_d    = HELD;
                    wait_cnt_d = '0;
                end
            end
            HELD: begin
                if (buf_drain || buf_kill) begin
                    state_d    = EMPTY;
                    wait_cnt_d = '0;
                end else if (grant_wb) begin
                    wait_cnt_d = wait_cnt_inc;
                    state_d    = (wait_cnt_inc == CNT_MAX) ? STARVED : HELD;
                end
            end
            STARVED: begin
                state_d    = EMPTY;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = EMPTY;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Write-port request for next cycle; index/data hold when nothing is granted.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (buf_drain) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = pend_rd;
            rf_data_d = pend_data;
        end else if (grant_wb && (wb_rd != RD_ZERO)) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = wb_rd;
            rf_data_d = wb_data;
        end
    end

    // State, counter and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= EMPTY;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench with a behavioural model of the write-port sharing rules.
module tb_regfile_wb_arbiter;

    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              clr;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_stall;
    logic              md_valid;
    logic [ADDR_W-1:0] md_rd;
    logic [WIDTH-1:0]  md_data;
    logic              md_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [WIDTH-1:0]  rf_data;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_rd;
    logic [WIDTH-1:0]  pend_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .md_valid   (md_valid),
        .md_rd      (md_rd),
        .md_data    (md_data),
        .md_ready   (md_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd),
        .pend_data  (pend_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buffer contents, lost-slot count and the write the port performs next cycle.
    bit                model_ok = 0;
    bit                m_pv;
    logic [ADDR_W-1:0] m_prd;
    logic [WIDTH-1:0]  m_pdata;
    int                m_lost;
    bit                m_we;
    logic [ADDR_W-1:0] m_rd;
    logic [WIDTH-1:0]  m_data;
    bit                had_entry;
    bit                wrote;
    logic [ADDR_W-1:0] w_rd;
    logic [WIDTH-1:0]  w_data;

    always @(posedge clk) begin
        if (clr) begin
            m_pv = 0; m_prd = '0; m_pdata = '0; m_lost = 0;
            m_we = 0; m_rd = '0; m_data = '0;
            model_ok = 1;
        end else if (model_ok) begin
            had_entry = m_pv;
            wrote = 0; w_rd = '0; w_data = '0;
            if (m_pv && m_lost >= MAX_WAIT) begin
                wrote = 1; w_rd = m_prd; w_data = m_pdata;
                m_pv = 0; m_prd = '0; m_pdata = '0; m_lost = 0;
            end else if (wb_valid) begin
                if (wb_rd != 0) begin
                    wrote = 1; w_rd = wb_rd; w_data = wb_data;
                end
                if (m_pv) begin
                    if (wb_rd == m_prd) begin
                        m_pv = 0; m_prd = '0; m_pdata = '0; m_lost = 0;
                    end else begin
                        m_lost = m_lost + 1;
                    end
                end
            end else if (m_pv) begin
                wrote = 1; w_rd = m_prd; w_data = m_pdata;
                m_pv = 0; m_prd = '0; m_pdata = '0; m_lost = 0;
            end
            if (!had_entry && md_valid && md_rd != 0) begin
                m_pv = 1; m_prd = md_rd; m_pdata = md_data; m_lost = 0;
            end
            m_we = wrote;
            if (wrote) begin
                m_rd = w_rd; m_data = w_data;
            end
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("md_ready",   64'(md_ready),   64'(!clr && !m_pv));
            check("wb_stall",   64'(wb_stall),   64'(!clr && wb_valid && m_pv && m_lost >= MAX_WAIT));
            check("pend_valid", 64'(pend_valid), 64'(m_pv));
            check("pend_rd",    64'(pend_rd),    64'(m_prd));
            check("pend_data",  64'(pend_data),  64'(m_pdata));
            check("rf_we",      64'(rf_we),      64'(m_we));
            check("rf_rd",      64'(rf_rd),      64'(m_rd));
            check("rf_data",    64'(rf_data),    64'(m_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic c, input logic wv, input logic [ADDR_W-1:0] wr,
                          input logic [WIDTH-1:0] wd, input logic mv,
                          input logic [ADDR_W-1:0] mr, input logic [WIDTH-1:0] mdd);
        clr = c; wb_valid = wv; wb_rd = wr; wb_data = wd;
        md_valid = mv; md_rd = mr; md_data = mdd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        md_valid = 1'b1; md_rd = 5'd2; md_data = 32'h1;

        // Reset held two cycles with a multdiv request pending
        step();
        check("rst_md_ready", 64'(md_ready), 64'd0);
        step();
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_pend_valid", 64'(pend_valid), 64'd0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("rel_md_ready", 64'(md_ready), 64'd1);
        $display("txn reset: md_ready=%0b rf_we=%0b pend_valid=%0b", md_ready, rf_we, pend_valid);

        // Idle drain
        set_in(0, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("drain_pend_valid", 64'(pend_valid), 64'd1);
        check("drain_pend_rd", 64'(pend_rd), 64'd7);
        check("drain_md_ready_busy", 64'(md_ready), 64'd0);
        step();
        check("drain_rf_we", 64'(rf_we), 64'd1);
        check("drain_rf_rd", 64'(rf_rd), 64'd7);
        check("drain_rf_data", 64'(rf_data), 64'hDEADBEEF);
        check("drain_md_ready", 64'(md_ready), 64'd1);
        $display("txn idle drain: rf_rd=%0d rf_data=%h", rf_rd, rf_data);
        step();
        check("drain_one_shot", 64'(rf_we), 64'd0);

        // Starvation: four pipeline grants then one forced drain
        set_in(0, 0, 0, 0, 1, 5'd3, 32'h33);
        step();
        for (int i = 0; i < MAX_WAIT; i++) begin
            set_in(0, 1, 5'd5, 32'h50 + i, 0, 0, 0);
            check("starve_no_stall", 64'(wb_stall), 64'd0);
            step();
            check("starve_wb_write", 64'(rf_data), 64'(32'h50 + i));
        end
        set_in(0, 1, 5'd5, 32'h99, 0, 0, 0);
        check("starve_stall", 64'(wb_stall), 64'd1);
        step();
        check("starve_buf_rd", 64'(rf_rd), 64'd3);
        check("starve_buf_data", 64'(rf_data), 64'h33);
        check("starve_stall_once", 64'(wb_stall), 64'd0);
        step();
        check("starve_resume_rd", 64'(rf_rd), 64'd5);
        check("starve_resume_data", 64'(rf_data), 64'h99);
        $display("txn starvation: resumed rf_rd=%0d rf_data=%h", rf_rd, rf_data);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();

        // Same-register kill
        set_in(0, 0, 0, 0, 1, 5'd9, 32'hAAAA);
        step();
        set_in(0, 1, 5'd9, 32'h11, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("kill_rf_rd", 64'(rf_rd), 64'd9);
        check("kill_rf_data", 64'(rf_data), 64'h11);
        check("kill_pend_valid", 64'(pend_valid), 64'd0);
        step();
        check("kill_no_md_write", 64'(rf_we), 64'd0);
        step();
        check("kill_no_md_write2", 64'(rf_we), 64'd0);
        $display("txn kill: r9 written once with 11, pend_valid=%0b", pend_valid);

        // Zero-register requests from both sides
        set_in(0, 1, 5'd0, 32'h456, 1, 5'd0, 32'h123);
        check("zero_md_ready", 64'(md_ready), 64'd1);
        check("zero_wb_stall", 64'(wb_stall), 64'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("zero_rf_we", 64'(rf_we), 64'd0);
        check("zero_pend_valid", 64'(pend_valid), 64'd0);
        step();
        check("zero_rf_we2", 64'(rf_we), 64'd0);
        $display("txn zero reg: rf_we=%0b pend_valid=%0b", rf_we, pend_valid);

        // Reset while a result is starved in the buffer
        set_in(0, 0, 0, 0, 1, 5'd4, 32'h44);
        step();
        for (int i = 0; i < MAX_WAIT; i++) begin
            set_in(0, 1, 5'd6, 32'h60 + i, 0, 0, 0);
            step();
        end
        set_in(1, 1, 5'd6, 32'h70, 0, 0, 0);
        check("midrst_no_stall", 64'(wb_stall), 64'd0);
        check("midrst_md_ready", 64'(md_ready), 64'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("midrst_pend_valid", 64'(pend_valid), 64'd0);
        check("midrst_rf_we", 64'(rf_we), 64'd0);
        step();
        check("midrst_no_r4", 64'(rf_we), 64'd0);
        $display("txn reset mid-op: pend_valid=%0b rf_we=%0b", pend_valid, rf_we);

        // Fresh entry after reset must get the full MAX_WAIT allowance again
        set_in(0, 0, 0, 0, 1, 5'd8, 32'h88);
        step();
        for (int i = 0; i < MAX_WAIT; i++) begin
            set_in(0, 1, 5'd10, 32'hA0 + i, 0, 0, 0);
            check("post_rst_no_stall", 64'(wb_stall), 64'd0);
            step();
        end
        set_in(0, 1, 5'd10, 32'hB0, 0, 0, 0);
        check("post_rst_stall", 64'(wb_stall), 64'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_buf_rd", 64'(rf_rd), 64'd8);
        $display("txn re-starve: rf_rd=%0d rf_data=%h", rf_rd, rf_data);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
